// File: rtl/fir31_lowpass.sv
// 31-tap symmetric low-pass FIR, time-multiplexed over one multiplier (one MAC per clock).
// Each accepted sample yields a full-precision result and a saturated 8-bit copy.
module fir31_lowpass #(
  parameter int NTAPS = 31,
  parameter int DW    = 8,
  parameter int CW    = 10,
  parameter int AW    = 20,
  parameter int SHIFT = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ready,
  input  logic [DW-1:0] x,
  output logic [AW-1:0] y,
  output logic [7:0]    y8,
  output logic          done,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic {IDLE, MAC} state_t;

  localparam logic [4:0]           LAST   = 5'(NTAPS - 1);
  localparam logic signed [AW-1:0] SAT_HI = AW'(127);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-128);

  state_t                state;
  logic signed [DW-1:0]  sample_buf [32];
  logic [4:0]            wp;
  logic [4:0]            newest;
  logic [4:0]            k;
  logic signed [AW-1:0]  acc;

  logic [4:0]            rd_addr;
  logic signed [AW-1:0]  coef_ext;
  logic signed [AW-1:0]  samp_ext;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  shifted;
  logic [7:0]            sat8;

  function automatic logic signed [CW-1:0] coef(input logic [4:0] idx);
    case (idx)
      5'd0,  5'd30: coef = CW'(-1);
      5'd1,  5'd29: coef = CW'(-1);
      5'd2,  5'd28: coef = CW'(-2);
      5'd3,  5'd27: coef = CW'(-2);
      5'd4,  5'd26: coef = CW'(-3);
      5'd5,  5'd25: coef = CW'(-3);
      5'd6,  5'd24: coef = CW'(-2);
      5'd7,  5'd23: coef = CW'(0);
      5'd8,  5'd22: coef = CW'(5);
      5'd9,  5'd21: coef = CW'(13);
      5'd10, 5'd20: coef = CW'(27);
      5'd11, 5'd19: coef = CW'(47);
      5'd12, 5'd18: coef = CW'(72);
      5'd13, 5'd17: coef = CW'(100);
      5'd14, 5'd16: coef = CW'(125);
      5'd15:        coef = CW'(274);
      default:      coef = '0;
    endcase
  endfunction

  // Tap k reads the sample k steps older than the newest; 5-bit subtraction gives the mod-32 wrap.
  always_comb begin
    rd_addr  = newest - k;
    coef_ext = AW'(coef(k));
    samp_ext = AW'(sample_buf[rd_addr]);
    prod     = coef_ext * samp_ext;
    acc_next = acc + prod;
    shifted  = acc_next >>> SHIFT;
    if (shifted > SAT_HI) begin
      sat8 = 8'h7F;
    end else if (shifted < SAT_LO) begin
      sat8 = 8'h80;
    end else begin
      sat8 = shifted[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        sample_buf[i] <= '0;
      end
      state   <= IDLE;
      wp      <= '0;
      newest  <= '0;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y8      <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            sample_buf[wp] <= x;
            newest         <= wp;
            wp             <= wp + 5'd1;
            acc            <= '0;
            k              <= '0;
            busy           <= 1'b1;
            state          <= MAC;
          end
        end
        MAC: begin
          if (ready) begin
            overrun <= 1'b1;
          end
          acc <= acc_next;
          if (k == LAST) begin
            y     <= acc_next;
            y8    <= sat8;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            k <= k + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
